// File: rtl/op_f_sched.sv
// op_f_sched: a round-robin scheduler that shares one two-output logic
// evaluation unit among NREQ requesters. It grants one requester at a time,
// captures that requester's operand, evaluates it and returns a tagged,
// registered result.
//
//   y = d | (a & ~b & c)
//   z = (b & d) | (a & ~c & d)   with operand bits {a,b,c,d} = [3:0]
//
// Each transaction takes three states: IDLE (arbitrate and capture), EVAL
// (register the result), RESP (strobe the result and advance the pointer).
module op_f_sched #(
  parameter  int NREQ = 4,
  parameter  int CNTW = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] opnd,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_y,
  output logic              rsp_z,
  output logic              busy,
  output logic [CNTW-1:0]   eval_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nxt;

  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [3:0]        r_op;
  logic [NREQ-1:0]   r_ack;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic              r_rsp_y;
  logic              r_rsp_z;
  logic [CNTW-1:0]   r_cnt;

  logic              w_any;
  logic [IDW-1:0]    w_win;
  int                w_idx;
  logic [3:0]        w_op;
  logic              w_y;
  logic              w_z;
  logic [IDW-1:0]    w_ptr_nxt;

  // State register; reset always returns to IDLE, which abandons any
  // in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic: a grant in IDLE starts a fixed three-state sequence.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = w_any ? S_EVAL : S_IDLE;
      S_EVAL:  w_nxt = S_RESP;
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Round-robin pick: scan downward from ptr+NREQ-1 to ptr so that the last
  // hit, i.e. the first set bit at or after ptr (with wrap), wins.
  always_comb begin
    w_any = |req;
    w_win = '0;
    w_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (req[w_idx]) w_win = IDW'(w_idx);
    end
  end

  // Operand of the current winner, captured at the grant edge.
  assign w_op = opnd[4*w_win +: 4];

  // The shared evaluation unit, fed only from the captured operand so that
  // later changes on opnd cannot affect an in-flight result.
  assign w_y = r_op[0] | (r_op[3] & ~r_op[2] & r_op[1]);
  assign w_z = (r_op[2] & r_op[0]) | (r_op[3] & ~r_op[1] & r_op[0]);

  // The pointer moves one past the requester just served, wrapping at NREQ.
  assign w_ptr_nxt = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

  // Datapath: capture on grant, register the result in EVAL, then retire
  // the transaction in RESP by updating the pointer and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= '0;
      r_ack       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 1'b0;
      r_rsp_z     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id  <= w_win;
            r_op  <= w_op;
            r_ack <= NREQ'(1) << w_win;
          end
        end
        S_EVAL: begin
          r_ack       <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_y     <= w_y;
          r_rsp_z     <= w_z;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_ptr       <= w_ptr_nxt;
          // Saturating count of completed evaluations.
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          r_ack       <= '0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_z     = r_rsp_z;
  assign busy      = (r_state != S_IDLE);
  assign eval_cnt  = r_cnt;

endmodule

// File: doc/op_f_sched.md
# op_f_sched

Round-robin scheduler that shares one OP_F-style two-output logic evaluation unit among NREQ requesters. Each requester presents a 4-bit operand {a,b,c,d} with a level request. The block grants one requester at a time and captures its operand. It evaluates y = d | (a & ~b & c) and z = (b & d) | (a & ~c & d), then returns a tagged, registered result. It sits between multiple client FSMs and the shared combinational function.

## Interface
- NREQ, default 4: number of requesters, legal range 2..8.
- CNTW, default 8: width of the saturating evaluation counter.
- IDW, derived as $clog2(NREQ): width of the requester ID.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request, level-sensitive, held until ack.
- opnd  in  4*NREQ  operand of requester i at [4i+3:4i], mapped as a=bit3, b=bit2, c=bit1, d=bit0.
- ack  out  NREQ  one-hot, one-cycle pulse confirming that requester's operand was captured.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  IDW  index of the requester the result belongs to.
- rsp_y  out  1  y result.
- rsp_z  out  1  z result.
- busy  out  1  high whenever state is not IDLE.
- eval_cnt  out  CNTW  completed evaluations, saturating at all-ones.

## Operation
- FSM states and transitions:
  - IDLE: if req is nonzero, go to EVAL; otherwise stay in IDLE.
  - EVAL: always go to RESP.
  - RESP: always go to IDLE.
- Arbitration happens only in IDLE.
  - Scan req starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - ptr resets to 0.
- On leaving IDLE:
  - Latch the winner into id_r and its operand into op_r.
  - Set ack[winner].
- In EVAL:
  - Compute y and z from op_r only; opnd and req changes are ignored.
  - Register rsp_y, rsp_z and rsp_id <= id_r.
  - Set rsp_valid.
  - Clear ack.
- In RESP:
  - Clear rsp_valid.
  - ptr <= (id_r + 1) mod NREQ.
  - eval_cnt increments, holding at 2^CNTW−1 once reached.
- rsp_y, rsp_z and rsp_id hold their last values until the next result; they are only meaningful while rsp_valid is high.
- Requester rule: a requester seeing ack high may drop req on the next cycle.
  - req is ignored during RESP.
  - If req is still high when IDLE next samples, it is treated as a new request.
- A requester holding req continuously is served again only after every other active requester has been served (round robin).
- Reset in any state:
  - Next state IDLE.
  - ack, rsp_valid, rsp_y, rsp_z, rsp_id, busy, eval_cnt, ptr, id_r and op_r all cleared to 0.
  - An in-flight transaction is abandoned: no rsp_valid is produced and eval_cnt is not incremented.

## Timing
- Request seen high in IDLE at edge t:
  - ack high in cycle t+1.
  - rsp_valid high in cycle t+2.
  - Earliest next grant at edge t+3.
- Latency is 2 cycles from grant edge to result.
- Throughput is one evaluation per 3 cycles under continuous demand.
- busy is high in cycles t+1 and t+2 only.
- ack and rsp_valid are never high in the same cycle, and each is exactly one cycle wide.
- The first cycle after rst deasserts is IDLE; a req already high in that cycle is granted at its ending edge.

## Test plan
- Reset: drive rst for 2 cycles with random req and opnd.
  - Required response: ack=0, rsp_valid=0, rsp_y=0, rsp_z=0, rsp_id=0, busy=0, eval_cnt=0.
- Single request, NREQ=4: req=4'b0001, opnd[3:0]=4'b1010.
  - ack=4'b0001 one cycle later.
  - rsp_valid one cycle after that, with rsp_id=0, rsp_y=1, rsp_z=0.
  - eval_cnt=1.
- Exhaustive check: requester 2 issues all 16 operands in sequence.
  - Each result matches the equations, e.g. 1101→y=1,z=1; 1001→y=1,z=1; 0100→y=0,z=0.
  - eval_cnt=16.
- Contention: req=4'b1111 held continuously.
  - Grant order 0,1,2,3,0.
  - ack pulses exactly 3 cycles apart.
  - rsp_id follows the same order.
- Mid-operation reset: rst asserted during EVAL.
  - No rsp_valid is produced.
  - The next grant with req=4'b1100 goes to requester 2, because ptr=0 after reset.
- Saturation: CNTW=8, 300 back-to-back evaluations.
  - eval_cnt stops at 255.
  - Results remain correct after the counter saturates.
